// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: arbitrates the cora16 fetch and data ports onto one serial
// RAM. Each request becomes a 48-bit mode-0 frame {cmd, addr24, data16}.
// Define SPI_MEM_WRITE_EN for read/write support. Without it the block is a
// read-only ROM front end, and data writes are acknowledged without a frame.
module spi_mem_ctrl #(
   parameter int          ADDR_W    = 16,
   parameter logic [7:0]  CMD_READ  = 8'h03,
   parameter logic [7:0]  CMD_WRITE = 8'h02
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ack,
   output logic [15:0]       fetch_data,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [15:0]       data_wdata,
   output logic              data_ack,
   output logic [15:0]       data_rdata,
   output logic              spi_select,
   output logic              spi_clk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state_q, state_d;
   logic [47:0] shreg_q, shreg_d;
   logic [5:0]  bit_q, bit_d;
   logic        phase_q, phase_d;
   logic [15:0] rdata_q, rdata_d;
   logic        gnt_data_q, gnt_data_d;
   logic        we_q, we_d;
   logic        last_data_q, last_data_d;
   logic [15:0] fetch_data_q, fetch_data_d;
   logic [15:0] data_rdata_q, data_rdata_d;

   logic        any_req;
   logic        pick_data;
   logic        pick_we;
   logic [7:0]  frame_cmd;
   logic [23:0] frame_addr;
   logic [15:0] frame_wdata;

   // Grant selection: a lone request wins; on a tie the port not served last wins.
   always_comb begin
      any_req    = fetch_req | data_req;
      pick_data  = data_req & (~fetch_req | ~last_data_q);
      pick_we    = pick_data & data_we;
      frame_addr = pick_data ? 24'(data_addr) : 24'(fetch_addr);
`ifdef SPI_MEM_WRITE_EN
      frame_cmd   = pick_we ? CMD_WRITE : CMD_READ;
      frame_wdata = pick_we ? data_wdata : 16'h0000;
`else
      frame_cmd   = CMD_READ;
      frame_wdata = 16'h0000;
`endif
   end

`ifndef SPI_MEM_WRITE_EN
   wire unused_wdata = ^data_wdata;
`endif

   // State and datapath registers. The async reset abandons any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         bit_q        <= '0;
         phase_q      <= 1'b0;
         rdata_q      <= '0;
         gnt_data_q   <= 1'b0;
         we_q         <= 1'b0;
         last_data_q  <= 1'b0;
         fetch_data_q <= '0;
         data_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_q        <= bit_d;
         phase_q      <= phase_d;
         rdata_q      <= rdata_d;
         gnt_data_q   <= gnt_data_d;
         we_q         <= we_d;
         last_data_q  <= last_data_d;
         fetch_data_q <= fetch_data_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   // Next state: grant and load the frame, then two clk cycles per bit, then one DONE cycle.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_d        = bit_q;
      phase_d      = phase_q;
      rdata_d      = rdata_q;
      gnt_data_d   = gnt_data_q;
      we_d         = we_q;
      last_data_d  = last_data_q;
      fetch_data_d = fetch_data_q;
      data_rdata_d = data_rdata_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt_data_d  = pick_data;
               we_d        = pick_we;
               last_data_d = pick_data;
               shreg_d     = {frame_cmd, frame_addr, frame_wdata};
               bit_d       = '0;
               phase_d     = 1'b0;
`ifdef SPI_MEM_WRITE_EN
               state_d     = SHIFT;
`else
               state_d     = pick_we ? DONE : SHIFT;
`endif
            end
         end
         SHIFT: begin
            if (!phase_q) begin
               phase_d = 1'b1;
               if (bit_q[5]) begin
                  rdata_d = {rdata_q[14:0], spi_miso};
               end
            end else begin
               phase_d = 1'b0;
               shreg_d = {shreg_q[46:0], 1'b0};
               bit_d   = bit_q + 6'd1;
               if (bit_q == 6'd47) begin
                  state_d = DONE;
                  if (!we_q) begin
                     if (gnt_data_q) begin
                        data_rdata_d = rdata_q;
                     end else begin
                        fetch_data_d = rdata_q;
                     end
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs: SPI pins are live only in SHIFT; acks pulse for the single DONE cycle.
   always_comb begin
      spi_select = (state_q == SHIFT);
      spi_clk    = (state_q == SHIFT) & phase_q;
      spi_mosi   = (state_q == SHIFT) & shreg_q[47];
      fetch_ack  = (state_q == DONE) & ~gnt_data_q;
      data_ack   = (state_q == DONE) & gnt_data_q;
      busy       = (state_q != IDLE);
      fetch_data = fetch_data_q;
      data_rdata = data_rdata_q;
   end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: drives the controller against a behavioural SPI RAM and
// compares results with a byte-array reference memory kept by the bench.
module tb_spi_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        fetch_req = 1'b0;
   logic [15:0] fetch_addr = '0;
   logic        fetch_ack;
   logic [15:0] fetch_data;
   logic        data_req = 1'b0;
   logic        data_we = 1'b0;
   logic [15:0] data_addr = '0;
   logic [15:0] data_wdata = '0;
   logic        data_ack;
   logic [15:0] data_rdata;
   logic        spi_select;
   logic        spi_clk;
   logic        spi_mosi;
   logic        spi_miso = 1'b0;
   logic        busy;

   int checkCount = 0;
   int errorCount = 0;

   logic [7:0]  devMem [0:65535];
   logic [7:0]  refMem [0:65535];
   logic [15:0] expFetch = '0;
   logic [15:0] expData = '0;

   int          bitCnt = 0;
   logic [47:0] shIn = '0;
   logic [15:0] rdWord = '0;
   logic        mosiAtNeg = 1'b0;
   int          frameCount = 0;
   int          selRises = 0;
   logic [7:0]  lastCmd = '0;
   logic [23:0] lastAddr = '0;
   logic [15:0] lastData = '0;

   spi_mem_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fetch_req  (fetch_req),
      .fetch_addr (fetch_addr),
      .fetch_ack  (fetch_ack),
      .fetch_data (fetch_data),
      .data_req   (data_req),
      .data_we    (data_we),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_ack   (data_ack),
      .data_rdata (data_rdata),
      .spi_select (spi_select),
      .spi_clk    (spi_clk),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .busy       (busy)
   );

   // 10 ns system clock
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Big-endian word from the reference memory, wrapping at 16 bits
   function automatic logic [15:0] refWord(input logic [15:0] a);
      logic [15:0] b;
      b = a + 16'd1;
      return {refMem[a], refMem[b]};
   endfunction

   // Word as the device currently holds it
   function automatic logic [15:0] devWord(input logic [15:0] a);
      logic [15:0] b;
      b = a + 16'd1;
      return {devMem[a], devMem[b]};
   endfunction

   // Device model: a new frame starts on select rising
   always @(posedge spi_select) begin
      bitCnt = 0;
      shIn   = '0;
      selRises++;
   end

   // Remember MOSI mid-cycle so the rising SPI clock can confirm it held still
   always @(negedge clk) mosiAtNeg = spi_mosi;

   // Device model: sample MOSI on rising SPI clock; fetch the read word after the address
   always @(posedge spi_clk) begin
      if (spi_select) begin
         checkOutput("mosiStable", {31'd0, spi_mosi}, {31'd0, mosiAtNeg});
         shIn = {shIn[46:0], spi_mosi};
         bitCnt++;
         if (bitCnt == 32) rdWord = devWord(shIn[15:0]);
      end
   end

   // Device model: present the next read bit after each falling SPI clock
   always @(negedge spi_clk) begin
      if (spi_select && bitCnt >= 32 && bitCnt < 48) spi_miso = rdWord[47 - bitCnt];
   end

   // Device model: a complete frame ends on select falling; writes commit here
   always @(negedge spi_select) begin
      if (bitCnt == 48) begin
         frameCount++;
         lastCmd  = shIn[47:40];
         lastAddr = shIn[39:16];
         lastData = shIn[15:0];
         if (lastCmd == 8'h02) begin
            devMem[lastAddr[15:0]]          = lastData[15:8];
            devMem[lastAddr[15:0] + 16'd1]  = lastData[7:0];
         end
      end
   end

   // Count clock edges until an ack is visible, within a bound
   task automatic waitAck(input int limit, output int lat, output bit seen);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < limit) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (fetch_ack || data_ack) seen = 1'b1;
      end
   endtask

   // One request on one port, checked against the reference memory and timing rules
   task automatic applyStimulus(input bit isData, input bit we, input logic [15:0] addr,
                                input logic [15:0] wdata);
      int   lat;
      bit   seen;
      bit   writeReq;
      int   framesBefore;
      int   risesBefore;
      int   expLat;
      framesBefore = frameCount;
      risesBefore  = selRises;
      writeReq     = isData && we;
      @(negedge clk);
      if (isData) begin
         data_req   = 1'b1;
         data_we    = we;
         data_addr  = addr;
         data_wdata = wdata;
      end else begin
         fetch_req  = 1'b1;
         fetch_addr = addr;
      end
      waitAck(300, lat, seen);
      checkOutput("ackSeen", {31'd0, seen}, 32'd1);
      if (seen) begin
`ifdef SPI_MEM_WRITE_EN
         expLat = 97;
`else
         expLat = writeReq ? 1 : 97;
`endif
         checkOutput("latency", lat, expLat);
         checkOutput("ackPort", {30'd0, fetch_ack, data_ack}, isData ? 32'd1 : 32'd2);
         checkOutput("busyDone", {31'd0, busy}, 32'd1);
         if (writeReq) begin
`ifdef SPI_MEM_WRITE_EN
            refMem[addr]         = wdata[15:8];
            refMem[addr + 16'd1] = wdata[7:0];
            checkOutput("wrFrames", frameCount, framesBefore + 1);
            checkOutput("wrCmd", {24'd0, lastCmd}, 32'h02);
            checkOutput("wrAddr", {8'd0, lastAddr}, {16'd0, addr});
            checkOutput("wrData", {16'd0, lastData}, {16'd0, wdata});
`else
            checkOutput("romFrames", frameCount, framesBefore);
            checkOutput("romSelect", selRises, risesBefore);
`endif
            checkOutput("memWord", {16'd0, devWord(addr)}, {16'd0, refWord(addr)});
         end else begin
            checkOutput("rdFrames", frameCount, framesBefore + 1);
            checkOutput("rdCmd", {24'd0, lastCmd}, 32'h03);
            checkOutput("rdAddr", {8'd0, lastAddr}, {16'd0, addr});
            if (isData) expData = refWord(addr);
            else        expFetch = refWord(addr);
         end
         checkOutput("fetchData", {16'd0, fetch_data}, {16'd0, expFetch});
         checkOutput("dataRdata", {16'd0, data_rdata}, {16'd0, expData});
      end
      fetch_req = 1'b0;
      data_req  = 1'b0;
      @(negedge clk);
      checkOutput("ackPulse", {30'd0, fetch_ack, data_ack}, 32'd0);
      checkOutput("busyIdle", {31'd0, busy}, 32'd0);
   endtask

   // Main sequence: reset, directed cases, random traffic, mid-frame reset, contention
   initial begin
      int   lat;
      bit   seen;
      int   cyc;
      int   ackIdx;
      int   prevAck;
      int   lowRun;
      bit   prevSel;
      bit   lastWasData;
      bit   expIsData;
      logic [15:0] fa;
      logic [15:0] da;

      for (int i = 0; i < 65536; i++) begin
         devMem[i] = 8'($urandom);
         refMem[i] = devMem[i];
      end
      devMem[16'h0010] = 8'hA5; devMem[16'h0011] = 8'h3C;
      devMem[16'h0200] = 8'h12; devMem[16'h0201] = 8'h34;
      devMem[16'h0300] = 8'h55; devMem[16'h0301] = 8'h55;
      devMem[16'h0302] = 8'hAA; devMem[16'h0303] = 8'hAA;
      foreach (refMem[i]) refMem[i] = devMem[i];

      #1 rst_n = 1'b0;
      #1;
      checkOutput("rstSelect", {31'd0, spi_select}, 32'd0);
      checkOutput("rstSpiClk", {31'd0, spi_clk}, 32'd0);
      checkOutput("rstMosi", {31'd0, spi_mosi}, 32'd0);
      checkOutput("rstAcks", {30'd0, fetch_ack, data_ack}, 32'd0);
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
      checkOutput("rstFetchData", {16'd0, fetch_data}, 32'd0);
      checkOutput("rstDataRdata", {16'd0, data_rdata}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000);
      checkOutput("fetchA53C", {16'd0, fetch_data}, 32'h0000A53C);
      applyStimulus(1'b1, 1'b1, 16'h0200, 16'hBEEF);
      applyStimulus(1'b1, 1'b0, 16'h0200, 16'h0000);
`ifdef SPI_MEM_WRITE_EN
      checkOutput("readBackBEEF", {16'd0, data_rdata}, 32'h0000BEEF);
`else
      checkOutput("readBack1234", {16'd0, data_rdata}, 32'h00001234);
`endif
      checkOutput("fetchHeld", {16'd0, fetch_data}, 32'h0000A53C);
      applyStimulus(1'b0, 1'b0, 16'h0300, 16'h0000);
      checkOutput("miso5555", {16'd0, fetch_data}, 32'h00005555);
      applyStimulus(1'b1, 1'b0, 16'h0302, 16'h0000);
      checkOutput("misoAAAA", {16'd0, data_rdata}, 32'h0000AAAA);

      for (int n = 0; n < 24; n++) begin
         bit isD;
         bit w;
         isD = 1'($urandom_range(0, 1));
         w   = isD & 1'($urandom_range(0, 1));
         applyStimulus(isD, w, 16'($urandom), 16'($urandom));
      end

      // Reset in the middle of a fetch frame, with the request left high
      fa = 16'($urandom);
      @(negedge clk);
      fetch_req  = 1'b1;
      fetch_addr = fa;
      @(posedge clk);
      repeat (40) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midRstSelect", {31'd0, spi_select}, 32'd0);
      checkOutput("midRstSpiClk", {31'd0, spi_clk}, 32'd0);
      checkOutput("midRstMosi", {31'd0, spi_mosi}, 32'd0);
      checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
      checkOutput("midRstFetch", {16'd0, fetch_data}, 32'd0);
      expFetch = '0;
      expData  = '0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("midRstNoAck", {30'd0, fetch_ack, data_ack}, 32'd0);
      end
      rst_n = 1'b1;
      waitAck(300, lat, seen);
      checkOutput("postRstAck", {31'd0, seen}, 32'd1);
      checkOutput("postRstLatency", lat, 97);
      checkOutput("postRstPort", {30'd0, fetch_ack, data_ack}, 32'd2);
      expFetch = refWord(fa);
      checkOutput("postRstFetch", {16'd0, fetch_data}, {16'd0, expFetch});
      checkOutput("postRstData", {16'd0, data_rdata}, 32'd0);
      fetch_req = 1'b0;
      repeat (2) @(negedge clk);

      // Both ports held from reset: grants alternate, data first
      fa = 16'($urandom);
      da = 16'($urandom);
      rst_n      = 1'b0;
      fetch_req  = 1'b1;
      fetch_addr = fa;
      data_req   = 1'b1;
      data_we    = 1'b0;
      data_addr  = da;
      expFetch   = '0;
      expData    = '0;
      @(negedge clk);
      rst_n       = 1'b1;
      cyc         = 0;
      ackIdx      = 0;
      prevAck     = 0;
      lowRun      = 0;
      prevSel     = 1'b0;
      lastWasData = 1'b0;
      while (ackIdx < 4 && cyc < 600) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (spi_select && !prevSel && ackIdx > 0)
            checkOutput("selGap", {31'd0, lowRun >= 1}, 32'd1);
         if (spi_select) lowRun = 0;
         else            lowRun++;
         prevSel = spi_select;
         if (fetch_ack || data_ack) begin
            expIsData   = ~lastWasData;
            lastWasData = expIsData;
            checkOutput("tiePort", {30'd0, fetch_ack, data_ack}, expIsData ? 32'd1 : 32'd2);
            if (ackIdx == 0) checkOutput("tieFirstAck", cyc, 97);
            else             checkOutput("tieSpacing", cyc - prevAck, 98);
            if (expIsData) expData = refWord(da);
            else           expFetch = refWord(fa);
            checkOutput("tieFetchData", {16'd0, fetch_data}, {16'd0, expFetch});
            checkOutput("tieDataRdata", {16'd0, data_rdata}, {16'd0, expData});
            prevAck = cyc;
            ackIdx++;
         end
      end
      checkOutput("tieAckCount", ackIdx, 4);
      fetch_req = 1'b0;
      data_req  = 1'b0;
      repeat (200) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
